// File: rtl/cnn_maxpool_stream_pkg.sv
// cnn_pkg: shared constants, sample type and helpers for the CNN streaming stages.
//   POOL_K          pooling window / stride
//   IMG_*_DEF       default feature-map geometry (28-pixel image after 3x3 valid conv)
//   cnn_acc_t       signed accumulator/sample type
//   smax(a, b)      signed maximum; on a tie the first operand is returned
package cnn_pkg;

  localparam int unsigned POOL_K         = 2;
  localparam int unsigned IMG_WIDTH_DEF  = 26;
  localparam int unsigned IMG_HEIGHT_DEF = 26;
  localparam int unsigned ACC_WIDTH      = 32;

  typedef logic signed [ACC_WIDTH-1:0] cnn_acc_t;

  function automatic cnn_acc_t smax(input cnn_acc_t a, input cnn_acc_t b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/cnn_maxpool_stream_rowbuf.sv
// cnn_pool_rowbuf: half-width row buffer holding the horizontal pair maxima of
// the even row until the matching odd row arrives.
// Synchronous write, asynchronous read, one port of each. No reset: contents
// are always written before they are read within a frame.
//   clk_i        clock
//   i_wr_en      write enable
//   i_wr_addr    write address (column pair index)
//   i_wr_data    write data
//   i_rd_addr    read address (column pair index)
//   o_rd_data    read data (combinational)
module cnn_pool_rowbuf
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ACC_WIDTH,
  parameter int unsigned DEPTH      = IMG_WIDTH_DEF / POOL_K,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/cnn_maxpool_stream.sv
// cnn_maxpool_stream: streaming 2x2 stride-2 signed max-pool stage.
// Consumes one sample per handshake in raster order and emits one pooled value
// per 2x2 block in raster order, one cycle after the block's bottom-right sample.
// Optional feature: define CNN_MAXPOOL_CNT_EN to add out_count_o.
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   clear_i       synchronous frame abort/restart (highest priority)
//   in_data_i     signed input sample
//   in_valid_i    input sample valid
//   in_ready_o    stage accepts a sample (from out_ready_i / clear_i only)
//   out_data_o    signed pooled result
//   out_valid_o   result valid
//   out_ready_i   downstream accepts result
//   frame_done_o  pulse when the last pooled value of a frame is accepted
//   out_count_o   (CNN_MAXPOOL_CNT_EN) accepted results in the current frame,
//                 saturating at 16'hFFFF, includes the one accepted this cycle
module cnn_maxpool_stream
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ACC_WIDTH,
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic signed [DATA_WIDTH-1:0] in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic signed [DATA_WIDTH-1:0] out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         frame_done_o
`ifdef CNN_MAXPOOL_CNT_EN
  ,
  output logic [15:0]                  out_count_o
`endif
);

  localparam int unsigned HALF_W = IMG_WIDTH / POOL_K;
  localparam int unsigned CW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  if ((IMG_WIDTH % POOL_K) != 0 || IMG_WIDTH == 0) begin : g_bad_width
    $error("cnn_maxpool_stream: IMG_WIDTH must be a non-zero even number");
  end
  if ((IMG_HEIGHT % POOL_K) != 0 || IMG_HEIGHT == 0) begin : g_bad_height
    $error("cnn_maxpool_stream: IMG_HEIGHT must be a non-zero even number");
  end
  if (DATA_WIDTH > ACC_WIDTH || DATA_WIDTH == 0) begin : g_bad_data_width
    $error("cnn_maxpool_stream: DATA_WIDTH must be 1..32");
  end

  logic [CW-1:0]                r_col;
  logic [RW-1:0]                r_row;
  logic signed [DATA_WIDTH-1:0] r_h;
  logic signed [DATA_WIDTH-1:0] r_out_data;
  logic                         r_out_valid;
  logic                         r_last;

  logic                         w_in_ready;
  logic                         w_accept;
  logic                         w_out_acc;
  logic                         w_col_odd;
  logic                         w_row_odd;
  logic                         w_col_last;
  logic                         w_row_last;
  logic                         w_rb_we;
  logic                         w_load;
  logic [AW-1:0]                w_rb_addr;
  logic [DATA_WIDTH-1:0]        w_rb_rdata;
  logic signed [DATA_WIDTH-1:0] w_pair_max;
  logic signed [DATA_WIDTH-1:0] w_pool_max;

  // Backpressure only through the output register; clear blocks input for its cycle.
  assign w_in_ready = !clear_i && (!r_out_valid || out_ready_i);
  assign w_accept   = in_valid_i && w_in_ready;
  assign w_out_acc  = r_out_valid && out_ready_i && !clear_i;

  assign w_col_odd  = r_col[0];
  assign w_row_odd  = r_row[0];
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_rb_addr  = AW'(r_col >> 1);

  assign w_rb_we    = w_accept && w_col_odd && !w_row_odd;
  assign w_load     = w_accept && w_col_odd && w_row_odd;

  // Sign-extend to the package type so smax compares full width, then narrow back.
  // Earlier operand goes first so ties keep it.
  assign w_pair_max = DATA_WIDTH'(smax(cnn_acc_t'(r_h), cnn_acc_t'(in_data_i)));
  assign w_pool_max = DATA_WIDTH'(smax(cnn_acc_t'($signed(w_rb_rdata)), cnn_acc_t'(w_pair_max)));

  cnn_pool_rowbuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (HALF_W)
  ) u_rowbuf (
    .clk_i     (clk_i),
    .i_wr_en   (w_rb_we),
    .i_wr_addr (w_rb_addr),
    .i_wr_data (w_pair_max),
    .i_rd_addr (w_rb_addr),
    .o_rd_data (w_rb_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_col <= '0;
      r_row <= '0;
    end else if (clear_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_h <= '0;
    end else if (w_accept && !w_col_odd) begin
      r_h <= in_data_i;
    end
  end

  // A fresh load takes precedence over the acceptance of the previous result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
    end else if (clear_i) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_pool_max;
      r_out_valid <= 1'b1;
      r_last      <= w_row_last && w_col_last;
    end else if (w_out_acc) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
    end
  end

  assign in_ready_o   = w_in_ready;
  assign out_data_o   = r_out_data;
  assign out_valid_o  = r_out_valid;
  assign frame_done_o = w_out_acc && r_last;

`ifdef CNN_MAXPOOL_CNT_EN
  logic [15:0] r_count;
  logic [15:0] w_count_next;

  assign w_count_next = (w_out_acc && (r_count != '1)) ? r_count + 16'd1 : r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (clear_i || frame_done_o) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  // Combinational view so the final acceptance is already counted while frame_done_o is high.
  assign out_count_o = w_count_next;
`endif

endmodule

// File: tb/tb_cnn_maxpool_stream.sv
module tb_cnn_maxpool_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic               s_clear, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_frame_done;
  logic signed [31:0] s_in_data, s_out_data;
  logic               b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_frame_done;
  logic signed [31:0] b_in_data, b_out_data;
`ifdef CNN_MAXPOOL_CNT_EN
  logic [15:0]        s_count, b_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  int f_basic [8] = '{1, 5, 2, 3, 4, 0, 9, -7};
  int f_neg   [8] = '{-8, -3, -5, -6, -4, -9, -2, -10};
  int f_clear [8] = '{7, 7, 7, 7, 7, 7, 7, 8};

  cnn_maxpool_stream #(
    .DATA_WIDTH (32),
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (2)
  ) u_small (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (s_clear),
    .in_data_i    (s_in_data),
    .in_valid_i   (s_in_valid),
    .in_ready_o   (s_in_ready),
    .out_data_o   (s_out_data),
    .out_valid_o  (s_out_valid),
    .out_ready_i  (s_out_ready),
    .frame_done_o (s_frame_done)
`ifdef CNN_MAXPOOL_CNT_EN
    ,
    .out_count_o  (s_count)
`endif
  );

  cnn_maxpool_stream u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (b_clear),
    .in_data_i    (b_in_data),
    .in_valid_i   (b_in_valid),
    .in_ready_o   (b_in_ready),
    .out_data_o   (b_out_data),
    .out_valid_o  (b_out_valid),
    .out_ready_i  (b_out_ready),
    .frame_done_o (b_frame_done)
`ifdef CNN_MAXPOOL_CNT_EN
    ,
    .out_count_o  (b_count)
`endif
  );

  task automatic test_reset;
    rst_n = 1'b0;
    s_clear = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    b_clear = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    #2;
    n_total++;
    if (s_out_valid !== 1'b0 || s_out_data !== 32'sd0 || s_frame_done !== 1'b0)
      $display("FAIL reset_small: valid=%b data=%0d done=%b, required 0/0/0", s_out_valid, s_out_data, s_frame_done);
    else n_pass++;
    n_total++;
    if (b_out_valid !== 1'b0 || b_out_data !== 32'sd0 || b_frame_done !== 1'b0)
      $display("FAIL reset_big: valid=%b data=%0d done=%b, required 0/0/0", b_out_valid, b_out_data, b_frame_done);
    else n_pass++;
    n_total++;
    if (s_in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %b, required 1", s_in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Streams one 4x2 frame at full throughput and checks both results and their timing.
  task automatic run_small_frame(input string name, input int v[8], input int e0, input int e1);
    s_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      s_in_data  = v[i];
      #1;
      if (i == 6) begin
        n_total++;
        if (s_out_valid !== 1'b1 || s_out_data !== e0 || s_frame_done !== 1'b0)
          $display("FAIL %s_first: valid=%b data=%0d done=%b, required 1/%0d/0", name, s_out_valid, s_out_data, s_frame_done, e0);
        else n_pass++;
      end
      if (i == 7) begin
        n_total++;
        if (s_out_valid !== 1'b0)
          $display("FAIL %s_gap: valid=%b, required 0", name, s_out_valid);
        else n_pass++;
      end
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    #1;
    n_total++;
    if (s_out_valid !== 1'b1 || s_out_data !== e1 || s_frame_done !== 1'b1)
      $display("FAIL %s_second: valid=%b data=%0d done=%b, required 1/%0d/1", name, s_out_valid, s_out_data, s_frame_done, e1);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (s_out_valid !== 1'b0 || s_frame_done !== 1'b0)
      $display("FAIL %s_drain: valid=%b done=%b, required 0/0", name, s_out_valid, s_frame_done);
    else n_pass++;
  endtask

  task automatic test_basic;
    run_small_frame("basic", f_basic, 5, 9);
  endtask

  task automatic test_negative;
    run_small_frame("negative", f_neg, -3, -2);
  endtask

  task automatic test_stall;
    s_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      s_in_data  = f_basic[i];
    end
    @(negedge clk);
    s_out_ready = 1'b0;
    s_in_data   = f_basic[6];
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_total++;
      if (s_out_valid !== 1'b1 || s_out_data !== 32'sd5 || s_in_ready !== 1'b0)
        $display("FAIL stall_hold_%0d: valid=%b data=%0d in_ready=%b, required 1/5/0", c, s_out_valid, s_out_data, s_in_ready);
      else n_pass++;
    end
    @(negedge clk);
    s_out_ready = 1'b1;
    #1;
    n_total++;
    if (s_in_ready !== 1'b1)
      $display("FAIL stall_release: in_ready=%b, required 1", s_in_ready);
    else n_pass++;
    @(negedge clk);
    s_in_data = f_basic[7];
    #1;
    n_total++;
    if (s_out_valid !== 1'b0)
      $display("FAIL stall_consumed: valid=%b, required 0", s_out_valid);
    else n_pass++;
    @(negedge clk);
    s_in_valid = 1'b0;
    #1;
    n_total++;
    if (s_out_valid !== 1'b1 || s_out_data !== 32'sd9 || s_frame_done !== 1'b1)
      $display("FAIL stall_second: valid=%b data=%0d done=%b, required 1/9/1", s_out_valid, s_out_data, s_frame_done);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_clear;
    s_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      s_in_data  = f_basic[i];
    end
    @(negedge clk);
    s_in_data = 32'sd100;
    s_clear   = 1'b1;
    #1;
    n_total++;
    if (s_in_ready !== 1'b0)
      $display("FAIL clear_in_ready: got %b, required 0", s_in_ready);
    else n_pass++;
    @(negedge clk);
    s_clear    = 1'b0;
    s_in_valid = 1'b0;
    #1;
    n_total++;
    if (s_out_valid !== 1'b0)
      $display("FAIL clear_out_valid: got %b, required 0", s_out_valid);
    else n_pass++;
    run_small_frame("clear", f_clear, 7, 8);
  endtask

  task automatic test_full_frame;
    int idx = 0;
    int k   = 0;
    int fd  = 0;
    int cyc = 0;
    int expv;
    bit cnt_pend = 1'b0;
    while (k < 169 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_in_valid  = (idx < 676) && ($urandom_range(0, 3) != 0);
      b_in_data   = idx;
      #1;
`ifdef CNN_MAXPOOL_CNT_EN
      if (cnt_pend) begin
        n_total++;
        if (b_count !== 16'd0) $display("FAIL count_after_done: got %0d, required 0", b_count);
        else n_pass++;
        cnt_pend = 1'b0;
      end
`endif
      if (b_frame_done) begin
        fd++;
`ifdef CNN_MAXPOOL_CNT_EN
        n_total++;
        if (b_count !== 16'd169) $display("FAIL count_at_done: got %0d, required 169", b_count);
        else n_pass++;
        cnt_pend = 1'b1;
`endif
      end
      if (b_out_valid && b_out_ready) begin
        expv = (2 * (k / 13) + 1) * 26 + 2 * (k % 13) + 1;
        n_total++;
        if (b_out_data !== expv)
          $display("FAIL frame_out_%0d: got %0d, required %0d", k, b_out_data, expv);
        else n_pass++;
        k++;
      end
      if (b_in_valid && b_in_ready) idx++;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
`ifdef CNN_MAXPOOL_CNT_EN
      if (cnt_pend) begin
        n_total++;
        if (b_count !== 16'd0) $display("FAIL count_after_done: got %0d, required 0", b_count);
        else n_pass++;
        cnt_pend = 1'b0;
      end
`endif
      if (b_frame_done) fd++;
      if (b_out_valid) k++;
    end
    n_total++;
    if (k != 169) $display("FAIL frame_count: got %0d outputs, required 169", k);
    else n_pass++;
    n_total++;
    if (fd != 1) $display("FAIL frame_done_count: got %0d pulses, required 1", fd);
    else n_pass++;
    n_total++;
    if (idx != 676) $display("FAIL frame_inputs: got %0d accepted, required 676", idx);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_stall();
    test_clear();
    test_full_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cnn_maxpool_stream.md
Name: cnn_maxpool_stream

Overview:
- Streaming 2x2 stride-2 max-pool stage directly downstream of the ReLU streaming stage in the CNN accelerator.
- Accepts the feature map one signed value per handshake in raster order and emits one pooled value per 2x2 block, also in raster order.
- Keeps a half-width row buffer of partial maxima, so no full-frame storage is needed.
- Output feeds the result writer through a ready/valid interface.

Parameters:
- DATA_WIDTH, 32, width of signed input/output samples.
- IMG_WIDTH, 26, feature-map columns (28-pixel image after 3x3 valid conv); must be even, elaboration error otherwise.
- IMG_HEIGHT, 26, feature-map rows; must be even, elaboration error otherwise.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous frame abort/restart.
- in_data_i  in  DATA_WIDTH  signed sample from ReLU stage.
- in_valid_i  in  1  sample valid.
- in_ready_o  out  1  stage accepts sample.
- out_data_o  out  DATA_WIDTH  signed pooled result.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts result.
- frame_done_o  out  1  one-cycle pulse when the last pooled value of a frame is accepted downstream.

Behaviour:
- Reset values: out_valid_o=0, out_data_o=0, frame_done_o=0. Column counter, row counter, horizontal hold register and row-buffer valid state all cleared. Row-buffer contents are don't-care.
- Input handshake: sample accepted when in_valid_i && in_ready_o. in_ready_o = !out_valid_o || out_ready_i, combinational from out_ready_i only; no path from in_valid_i.
- Counters: col (0..IMG_WIDTH-1) increments per accepted sample. At IMG_WIDTH-1, col wraps to 0 and row increments (0..IMG_HEIGHT-1). row wraps to 0 after the last sample of a frame.
- Even col: sample stored in hold register h.
- Odd col: pair max m = signed max(h, in_data_i).
  - Even row: m is written to rowbuf[col>>1].
  - Odd row: result r = signed max(m, rowbuf[col>>1]). r is registered into out_data_o and out_valid_o=1 on the next edge, i.e. 1-cycle latency after the bottom-right sample.
- All comparisons are signed and full width. Ties keep the earlier operand (bit-identical either way).
- Output register: holds data stable while out_valid_o && !out_ready_i. Cleared on acceptance unless a new result is loaded in the same cycle; back-to-back acceptance is allowed. Stalls propagate upstream only through in_ready_o.
- Results per frame: exactly (IMG_WIDTH/2)*(IMG_HEIGHT/2).
- frame_done_o: asserted the cycle the final result of the frame is accepted (out_valid_o && out_ready_i && last-flag). The last-flag is set when the final result is loaded.
- clear_i: has priority over everything. Zeroes counters, out_valid_o and the last-flag; drops any pending output. in_ready_o is forced 0 during the clear cycle. Next accepted sample is col 0, row 0.
- Reset mid-frame: same as clear, but asynchronous.
- Simultaneous output acceptance and new result load in the same cycle: the new result wins and out_valid_o stays 1.

Optional Feature:
- Macro: CNN_MAXPOOL_CNT_EN.
- Defined: adds port out_count_o (out, 16) counting accepted output results since the last reset/clear/frame_done. It saturates at 16'hFFFF and resets to 0 the cycle after frame_done_o.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- cnn_pkg holds: POOL_K=2 constant, default IMG_WIDTH/IMG_HEIGHT, a function smax(a,b) for signed maximum, and the sample typedef cnn_acc_t (logic signed [31:0]).
- One sub-module: cnn_pool_rowbuf, an IMG_WIDTH/2-entry synchronous-write, asynchronous-read register file, one write port and one read port.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, rows [1,5,2,3]/[4,0,9,-7], out_ready_i=1 -> outputs 5 then 9, 1 cycle after samples 6 and 8; frame_done_o pulses with the 9.
- All-negative frame [-8,-3,-5,-6]/[-4,-9,-2,-10] -> outputs -3, -2 (signed compare checked); 0 output is a fail.
- Same as first, out_ready_i=0 for 5 cycles after first result -> out_data_o holds 5, in_ready_o=0 during stall, no sample lost; 9 follows after release.
- clear_i asserted after 3 samples of row 0, then a full fresh frame [7,7,7,7]/[7,7,7,8] -> outputs 7, 8; no residue from the aborted frame.
- Default 26x26 frame, ramp value=row*26+col, random in_valid_i/out_ready_i -> 169 outputs equal to value at (2i+1, 2j+1); exactly one frame_done_o.
- With CNN_MAXPOOL_CNT_EN: 26x26 frame -> out_count_o reaches 169 at frame_done_o, then 0 the following cycle.
